// File: rtl/interrupt_sequencer.sv
// 6502 interrupt/BRK/reset micro-sequencer: forces BRK on hardware interrupts,
// steers the PCH/PCL/P stack pushes, sets I and produces vector fetch addresses.
module interrupt_sequencer #(
  parameter logic [15:0] VEC_NMI = 16'hFFFA,
  parameter logic [15:0] VEC_RST = 16'hFFFC,
  parameter logic [15:0] VEC_IRQ = 16'hFFFE
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_rdy,
  input  logic        i_sync,
  input  logic        i_brk,
  input  logic        i_nmi_n,
  input  logic        i_irq_n,
  input  logic        i_p_i,
  output logic        o_force_brk,
  output logic        o_busy,
  output logic [2:0]  o_state,
  output logic [1:0]  o_push_sel,
  output logic        o_write,
  output logic        o_sp_dec,
  output logic        o_pc_inc,
  output logic        o_b_flag,
  output logic        o_set_i,
  output logic [15:0] o_vec_addr,
  output logic        o_nmi_taken
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DUMMY    = 3'd1,
    S_PUSH_PCH = 3'd2,
    S_PUSH_PCL = 3'd3,
    S_PUSH_P   = 3'd4,
    S_VEC_LO   = 3'd5,
    S_VEC_HI   = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    K_BRK = 2'd0,
    K_IRQ = 2'd1,
    K_NMI = 2'd2,
    K_RST = 2'd3
  } kind_t;

  typedef enum logic [1:0] {
    V_IRQ = 2'd0,
    V_NMI = 2'd1,
    V_RST = 2'd2
  } vsel_t;

  state_t state, state_nxt;
  kind_t  kind, kind_nxt;
  vsel_t  vec_sel, vec_sel_nxt;
  logic   rst_pend, rst_pend_nxt;
  logic   nmi_pend, nmi_pend_nxt;
  logic   nmi_prev;
  logic   nmi_taken_nxt;
  logic   irq_req;
  logic   nmi_edge;
  logic   push_nxt;

  function automatic logic [15:0] vec_base(input vsel_t v);
    case (v)
      V_NMI:   vec_base = VEC_NMI;
      V_RST:   vec_base = VEC_RST;
      default: vec_base = VEC_IRQ;
    endcase
  endfunction

  assign irq_req     = ~i_irq_n & ~i_p_i;
  assign nmi_edge    = nmi_prev & ~i_nmi_n;
  assign o_force_brk = (state == S_IDLE) & i_sync & (rst_pend | nmi_pend | irq_req);
  assign o_state     = state;
  assign push_nxt    = (state_nxt == S_PUSH_PCH) | (state_nxt == S_PUSH_PCL) |
                       (state_nxt == S_PUSH_P);

  always_comb begin
    state_nxt     = state;
    kind_nxt      = kind;
    vec_sel_nxt   = vec_sel;
    rst_pend_nxt  = rst_pend;
    nmi_pend_nxt  = nmi_pend;
    nmi_taken_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_sync & i_rdy & (o_force_brk | i_brk)) begin
          state_nxt = S_DUMMY;
          if (rst_pend)      kind_nxt = K_RST;
          else if (nmi_pend) kind_nxt = K_NMI;
          else if (irq_req)  kind_nxt = K_IRQ;
          else               kind_nxt = K_BRK;
        end
      end
      S_DUMMY:    if (i_rdy) state_nxt = S_PUSH_PCH;
      S_PUSH_PCH: state_nxt = S_PUSH_PCL;
      S_PUSH_PCL: state_nxt = S_PUSH_P;
      S_PUSH_P: begin
        state_nxt = S_VEC_LO;
        // A pending NMI hijacks an IRQ/BRK sequence at the last moment.
        if (kind == K_RST)                     vec_sel_nxt = V_RST;
        else if ((kind == K_NMI) || nmi_pend)  vec_sel_nxt = V_NMI;
        else                                   vec_sel_nxt = V_IRQ;
        if (vec_sel_nxt == V_NMI) begin
          nmi_pend_nxt  = 1'b0;
          nmi_taken_nxt = 1'b1;
        end
        if (kind == K_RST) rst_pend_nxt = 1'b0;
      end
      S_VEC_LO:   if (i_rdy) state_nxt = S_VEC_HI;
      S_VEC_HI:   if (i_rdy) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
    // A fresh edge outranks the clear on vector commit.
    if (nmi_edge) nmi_pend_nxt = 1'b1;
  end

  // Outputs are registered from the next-state values so they track the state register exactly.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state       <= S_IDLE;
      kind        <= K_BRK;
      vec_sel     <= V_IRQ;
      rst_pend    <= 1'b1;
      nmi_pend    <= 1'b0;
      nmi_prev    <= 1'b1;
      o_busy      <= 1'b0;
      o_push_sel  <= 2'd3;
      o_write     <= 1'b0;
      o_sp_dec    <= 1'b0;
      o_pc_inc    <= 1'b0;
      o_b_flag    <= 1'b0;
      o_set_i     <= 1'b0;
      o_vec_addr  <= 16'h0000;
      o_nmi_taken <= 1'b0;
    end else begin
      state       <= state_nxt;
      kind        <= kind_nxt;
      vec_sel     <= vec_sel_nxt;
      rst_pend    <= rst_pend_nxt;
      nmi_pend    <= nmi_pend_nxt;
      nmi_prev    <= i_nmi_n;
      o_busy      <= (state_nxt != S_IDLE);
      case (state_nxt)
        S_PUSH_PCH: o_push_sel <= 2'd0;
        S_PUSH_PCL: o_push_sel <= 2'd1;
        S_PUSH_P:   o_push_sel <= 2'd2;
        default:    o_push_sel <= 2'd3;
      endcase
      o_write     <= push_nxt & (kind_nxt != K_RST);
      o_sp_dec    <= push_nxt;
      o_pc_inc    <= (state_nxt == S_DUMMY) & (kind_nxt == K_BRK);
      o_b_flag    <= (state_nxt == S_PUSH_P) & (kind_nxt == K_BRK);
      o_set_i     <= (state_nxt == S_VEC_LO);
      case (state_nxt)
        S_VEC_LO: o_vec_addr <= vec_base(vec_sel_nxt);
        S_VEC_HI: o_vec_addr <= vec_base(vec_sel_nxt) + 16'd1;
        default:  o_vec_addr <= 16'h0000;
      endcase
      o_nmi_taken <= nmi_taken_nxt;
    end
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Bench for interrupt_sequencer: directed scenarios plus random stimulus, all
// compared against a sequence-step reference model.
module tb_interrupt_sequencer;

  logic        i_clk = 1'b0;
  logic        i_reset_n, i_rdy, i_sync, i_brk, i_nmi_n, i_irq_n, i_p_i;
  logic        o_force_brk, o_busy, o_write, o_sp_dec, o_pc_inc, o_b_flag, o_set_i, o_nmi_taken;
  logic [2:0]  o_state;
  logic [1:0]  o_push_sel;
  logic [15:0] o_vec_addr;
  logic [28:0] dut_out;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: step number 0..6 through the sequence, plus pending flags
  int          m_phase = 0;
  int          m_kind = 0;
  logic        m_rst_pend = 1'b1;
  logic        m_nmi_pend = 1'b0;
  logic        m_nmi_prev = 1'b1;
  logic        m_taken = 1'b0;
  logic [15:0] m_vec = 16'hFFFE;

  interrupt_sequencer dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_rdy(i_rdy), .i_sync(i_sync), .i_brk(i_brk),
    .i_nmi_n(i_nmi_n), .i_irq_n(i_irq_n), .i_p_i(i_p_i),
    .o_force_brk(o_force_brk), .o_busy(o_busy), .o_state(o_state), .o_push_sel(o_push_sel),
    .o_write(o_write), .o_sp_dec(o_sp_dec), .o_pc_inc(o_pc_inc), .o_b_flag(o_b_flag),
    .o_set_i(o_set_i), .o_vec_addr(o_vec_addr), .o_nmi_taken(o_nmi_taken)
  );

  always #5 i_clk = ~i_clk;

  assign dut_out = {o_force_brk, o_busy, o_state, o_push_sel, o_write, o_sp_dec, o_pc_inc,
                    o_b_flag, o_set_i, o_vec_addr, o_nmi_taken};

  function automatic logic model_force();
    return (m_phase == 0) && i_sync && (m_rst_pend || m_nmi_pend || (!i_irq_n && !i_p_i));
  endfunction

  function automatic logic [28:0] model_out();
    logic        push;
    logic [1:0]  sel;
    logic [15:0] addr;
    push = (m_phase >= 2) && (m_phase <= 4);
    sel  = push ? 2'(m_phase - 2) : 2'd3;
    addr = (m_phase == 5) ? m_vec : (m_phase == 6) ? m_vec + 16'd1 : 16'h0000;
    return {model_force(), m_phase != 0, 3'(m_phase), sel, push && (m_kind != 3), push,
            (m_phase == 1) && (m_kind == 0), (m_phase == 4) && (m_kind == 0),
            m_phase == 5, addr, m_taken};
  endfunction

  // Kinds: 0=BRK 1=IRQ 2=NMI 3=RST; evaluated with the inputs present at the clock edge
  function automatic void model_step();
    logic edge_seen;
    if (!i_reset_n) begin
      m_phase = 0; m_kind = 0; m_rst_pend = 1'b1; m_nmi_pend = 1'b0;
      m_nmi_prev = 1'b1; m_taken = 1'b0; m_vec = 16'hFFFE;
      return;
    end
    edge_seen = m_nmi_prev && !i_nmi_n;
    m_nmi_prev = i_nmi_n;
    m_taken = 1'b0;
    case (m_phase)
      0: if (i_sync && i_rdy && (model_force() || i_brk)) begin
           m_kind  = m_rst_pend ? 3 : m_nmi_pend ? 2 : (!i_irq_n && !i_p_i) ? 1 : 0;
           m_phase = 1;
         end
      1, 5, 6: if (i_rdy) m_phase = (m_phase + 1) % 7;
      2, 3: m_phase = m_phase + 1;
      4: begin
           m_vec = (m_kind == 3) ? 16'hFFFC : ((m_kind == 2) || m_nmi_pend) ? 16'hFFFA : 16'hFFFE;
           if (m_vec == 16'hFFFA) begin
             m_nmi_pend = 1'b0;
             m_taken = 1'b1;
           end
           if (m_kind == 3) m_rst_pend = 1'b0;
           m_phase = 5;
         end
      default: m_phase = 0;
    endcase
    if (edge_seen) m_nmi_pend = 1'b1;
  endfunction

  task automatic tick();
    @(posedge i_clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0; i_rdy = 1'b1; i_sync = 1'b0; i_brk = 1'b0;
    i_nmi_n = 1'b1; i_irq_n = 1'b1; i_p_i = 1'b1;
    tick(); tick(); #1;
    vectors++;
    if (dut_out !== {1'b0, 1'b0, 3'd0, 2'd3, 5'b0, 16'h0000, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got %h expected %h", dut_out, {1'b0, 1'b0, 3'd0, 2'd3, 5'b0, 16'h0000, 1'b0});
    end
    vectors++;
    if (dut_out !== model_out()) begin
      miscompares++;
      $display("[TB] FAIL reset_model: got %h expected %h", dut_out, model_out());
    end
    i_reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset_sequence();
    i_sync = 1'b1; #1;
    vectors++;
    if (o_force_brk !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rst_force_brk: got %b expected 1", o_force_brk);
    end
    tick();
    i_sync = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      #1;
      vectors++;
      if (o_state !== 3'(c) || o_write !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL rst_seq_state c=%0d: got state %0d write %b expected state %0d write 0", c, o_state, o_write, c);
      end
      vectors++;
      if (dut_out !== model_out()) begin
        miscompares++;
        $display("[TB] FAIL rst_seq_model c=%0d: got %h expected %h", c, dut_out, model_out());
      end
      if (c == 5) begin
        vectors++;
        if (o_vec_addr !== 16'hFFFC || o_set_i !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL rst_vec_lo: got %h/%b expected FFFC/1", o_vec_addr, o_set_i);
        end
      end
      tick();
    end
    i_sync = 1'b1; #1;
    vectors++;
    if (o_force_brk !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rst_pend_cleared: got %b expected 0", o_force_brk);
    end
    tick();
    i_sync = 1'b0;
  endtask

  task automatic test_brk();
    i_sync = 1'b1; i_brk = 1'b1; #1;
    vectors++;
    if (o_force_brk !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL brk_no_force: got %b expected 0", o_force_brk);
    end
    tick();
    i_sync = 1'b0; i_brk = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      #1;
      vectors++;
      if (dut_out !== model_out()) begin
        miscompares++;
        $display("[TB] FAIL brk_model c=%0d: got %h expected %h", c, dut_out, model_out());
      end
      if (c == 1 || c == 4 || c == 5) begin
        vectors++;
        if ((c == 1 && o_pc_inc !== 1'b1) || (c == 4 && (o_b_flag !== 1'b1 || o_write !== 1'b1)) ||
            (c == 5 && o_vec_addr !== 16'hFFFE)) begin
          miscompares++;
          $display("[TB] FAIL brk_step c=%0d: got pc_inc %b b %b wr %b vec %h expected pc_inc@1 b,wr@4 FFFE@5",
                   c, o_pc_inc, o_b_flag, o_write, o_vec_addr);
        end
      end
      tick();
    end
  endtask

  task automatic test_irq();
    i_irq_n = 1'b0; i_p_i = 1'b1; i_sync = 1'b1; #1;
    vectors++;
    if (o_force_brk !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL irq_masked_force: got %b expected 0", o_force_brk);
    end
    tick(); #1;
    vectors++;
    if (o_busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL irq_masked_busy: got %b expected 0", o_busy);
    end
    i_p_i = 1'b0; #1;
    vectors++;
    if (o_force_brk !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL irq_force: got %b expected 1", o_force_brk);
    end
    tick();
    i_sync = 1'b0; i_irq_n = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      #1;
      vectors++;
      if (dut_out !== model_out()) begin
        miscompares++;
        $display("[TB] FAIL irq_model c=%0d: got %h expected %h", c, dut_out, model_out());
      end
      if (c == 4 || c == 5) begin
        vectors++;
        if ((c == 4 && o_b_flag !== 1'b0) || (c == 5 && o_vec_addr !== 16'hFFFE)) begin
          miscompares++;
          $display("[TB] FAIL irq_step c=%0d: got b %b vec %h expected b 0, vec FFFE", c, o_b_flag, o_vec_addr);
        end
      end
      tick();
    end
    i_p_i = 1'b1;
  endtask

  task automatic test_nmi_hijack();
    i_p_i = 1'b0; i_irq_n = 1'b0; i_sync = 1'b1;
    tick();
    i_sync = 1'b0; i_irq_n = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      if (c == 3) i_nmi_n = 1'b0;
      #1;
      vectors++;
      if (dut_out !== model_out()) begin
        miscompares++;
        $display("[TB] FAIL hijack_model c=%0d: got %h expected %h", c, dut_out, model_out());
      end
      if (c == 5 || c == 6) begin
        vectors++;
        if ((c == 5 && (o_vec_addr !== 16'hFFFA || o_nmi_taken !== 1'b1)) ||
            (c == 6 && (o_vec_addr !== 16'hFFFB || o_nmi_taken !== 1'b0))) begin
          miscompares++;
          $display("[TB] FAIL hijack_vec c=%0d: got %h taken %b expected FFFA/1 then FFFB/0", c, o_vec_addr, o_nmi_taken);
        end
      end
      tick();
    end
    i_nmi_n = 1'b1; i_p_i = 1'b1; i_sync = 1'b1; #1;
    vectors++;
    if (o_force_brk !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL hijack_pend_cleared: got %b expected 0", o_force_brk);
    end
    tick();
    i_sync = 1'b0;
  endtask

  task automatic test_nmi_late();
    i_sync = 1'b1; i_brk = 1'b1;
    tick();
    i_sync = 1'b0; i_brk = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (c == 6) i_nmi_n = 1'b0;
      #1;
      vectors++;
      if (dut_out !== model_out()) begin
        miscompares++;
        $display("[TB] FAIL nmi_late_model c=%0d: got %h expected %h", c, dut_out, model_out());
      end
      tick();
    end
    i_sync = 1'b1; #1;
    vectors++;
    if (o_force_brk !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL nmi_late_force: got %b expected 1", o_force_brk);
    end
    tick();
    i_sync = 1'b0; i_nmi_n = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      #1;
      vectors++;
      if (dut_out !== model_out() || (c == 5 && (o_vec_addr !== 16'hFFFA || o_nmi_taken !== 1'b1))) begin
        miscompares++;
        $display("[TB] FAIL nmi_late_seq c=%0d: got %h expected %h (vec FFFA at step 5)", c, dut_out, model_out());
      end
      tick();
    end
  endtask

  task automatic test_rdy_stall();
    int rdy_pat[12] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1};
    int st_pat[12]  = '{1, 1, 1, 1, 2, 3, 4, 5, 5, 5, 5, 6};
    i_sync = 1'b1; i_brk = 1'b1;
    tick();
    i_sync = 1'b0; i_brk = 1'b0;
    for (int c = 0; c < 12; c++) begin
      i_rdy = rdy_pat[c][0];
      #1;
      vectors++;
      if (o_state !== 3'(st_pat[c]) || o_set_i !== (st_pat[c] == 5)) begin
        miscompares++;
        $display("[TB] FAIL stall_state c=%0d: got state %0d set_i %b expected state %0d", c, o_state, o_set_i, st_pat[c]);
      end
      vectors++;
      if (dut_out !== model_out()) begin
        miscompares++;
        $display("[TB] FAIL stall_model c=%0d: got %h expected %h", c, dut_out, model_out());
      end
      tick();
    end
    i_rdy = 1'b1;
  endtask

  task automatic test_reset_abort();
    i_sync = 1'b1; i_brk = 1'b1;
    tick();
    i_sync = 1'b0; i_brk = 1'b0;
    tick(); tick();
    i_reset_n = 1'b0;
    tick();
    i_reset_n = 1'b1; #1;
    vectors++;
    if (o_state !== 3'd0 || o_busy !== 1'b0 || o_write !== 1'b0 || o_sp_dec !== 1'b0 || o_push_sel !== 2'd3) begin
      miscompares++;
      $display("[TB] FAIL abort_idle: got state %0d busy %b wr %b sp %b sel %0d expected 0 0 0 0 3",
               o_state, o_busy, o_write, o_sp_dec, o_push_sel);
    end
    i_sync = 1'b1; #1;
    vectors++;
    if (o_force_brk !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL abort_force: got %b expected 1", o_force_brk);
    end
    tick();
    i_sync = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      #1;
      vectors++;
      if (dut_out !== model_out() || (c == 5 && o_vec_addr !== 16'hFFFC)) begin
        miscompares++;
        $display("[TB] FAIL abort_seq c=%0d: got %h expected %h (vec FFFC at step 5)", c, dut_out, model_out());
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      i_reset_n = ($urandom_range(0, 99) != 0);
      i_rdy     = ($urandom_range(0, 3) != 0);
      i_sync    = ($urandom_range(0, 2) == 0);
      i_brk     = ($urandom_range(0, 3) == 0);
      i_irq_n   = ($urandom_range(0, 2) != 0);
      i_p_i     = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 7) == 0) i_nmi_n = ~i_nmi_n;
      #1;
      vectors++;
      if (dut_out !== model_out()) begin
        miscompares++;
        $display("[TB] FAIL random n=%0d: got %h expected %h", n, dut_out, model_out());
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_reset_sequence();
    test_brk();
    test_irq();
    test_nmi_hijack();
    test_nmi_late();
    test_rdy_stall();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
- Sequences the 6502 interrupt/BRK/reset micro-sequence around the processor status register and stack: it forces BRK on hardware interrupts, steers the three stack pushes (PCH, PCL, P), sets the I flag and produces vector fetch addresses.
- Sits beside the instruction decoder. It drives status-register controls (B bit for pushed P, set-I strobe) and address/stack-pointer controls. Priority is RESET > NMI > IRQ > BRK.

Parameters:
- VEC_NMI, 16'hFFFA, NMI vector low-byte address
- VEC_RST, 16'hFFFC, reset vector low-byte address
- VEC_IRQ, 16'hFFFE, IRQ/BRK vector low-byte address

Ports:
- i_clk  input  1  clock, all state updates on posedge
- i_reset_n  input  1  synchronous active-low reset
- i_rdy  input  1  ready; low stalls read cycles
- i_sync  input  1  opcode-fetch cycle (instruction boundary)
- i_brk  input  1  opcode being fetched this sync cycle is 0x00
- i_nmi_n  input  1  NMI pin, falling-edge sensitive
- i_irq_n  input  1  IRQ pin, level sensitive
- i_p_i  input  1  current I flag from status register
- o_force_brk  output  1  load IR with 0x00 instead of fetched opcode (combinational)
- o_busy  output  1  sequence in progress
- o_state  output  3  current state encoding, for debug
- o_push_sel  output  2  stack data source: 0=PCH, 1=PCL, 2=P, 3=none
- o_write  output  1  bus write enable for push cycle
- o_sp_dec  output  1  decrement stack pointer this cycle
- o_pc_inc  output  1  increment PC (BRK padding byte skip)
- o_b_flag  output  1  B bit value to insert into pushed P
- o_set_i  output  1  strobe: set I flag in status register
- o_vec_addr  output  16  vector fetch address, 0 outside vector states
- o_nmi_taken  output  1  one-cycle pulse when NMI vector is committed

Behaviour:
- States: IDLE=0, DUMMY=1, PUSH_PCH=2, PUSH_PCL=3, PUSH_P=4, VEC_LO=5, VEC_HI=6. Outputs are decoded from state (Moore), except o_force_brk.
- Reset (i_reset_n=0 at posedge): state=IDLE, rst_pend=1, nmi_pend=0, nmi_prev=1, kind=BRK, vec_sel=IRQ. All outputs are 0, except o_push_sel=3 and o_state=0. A reset mid-sequence aborts it. No partial push is completed afterwards.
- NMI edge: each cycle nmi_prev<=i_nmi_n. A 1→0 transition sets nmi_pend. nmi_pend is cleared on entry to VEC_LO when vec_sel=NMI. If a new edge and the clear happen in the same cycle, the set wins.
- irq_req = ~i_irq_n & ~i_p_i. The level is sampled only in the IDLE sync cycle and is not latched.
- o_force_brk = (state==IDLE) & i_sync & (rst_pend | nmi_pend | irq_req).
- IDLE→DUMMY on i_sync & i_rdy & (o_force_brk | i_brk). kind is latched on this transition: RST if rst_pend, else NMI if nmi_pend, else IRQ if irq_req, else BRK.
- DUMMY→PUSH_PCH (stalls while i_rdy=0). o_pc_inc=1 in DUMMY only when kind=BRK.
- PUSH_PCH→PUSH_PCL→PUSH_P: one cycle each, advance regardless of i_rdy.
  - In each push state: o_sp_dec=1, o_write=(kind!=RST), o_push_sel=0/1/2 respectively.
  - o_b_flag=(kind==BRK) in PUSH_P, 0 elsewhere.
- PUSH_P→VEC_LO: vec_sel latched here.
  - kind RST → RST; kind NMI → NMI.
  - kind IRQ/BRK → NMI if nmi_pend (hijack), else IRQ.
  - A hijacked BRK still pushes B=1.
- VEC_LO (stalls while i_rdy=0): o_vec_addr=selected vector, o_set_i=1 each cycle in state. o_nmi_taken pulses on the entry cycle if vec_sel=NMI. rst_pend is cleared on entry if kind=RST.
- VEC_HI (stalls while i_rdy=0): o_vec_addr=selected vector+1 → IDLE.
- o_busy=(state!=IDLE). o_push_sel=3 outside push states.
- An NMI edge arriving during or after VEC_LO stays pending and is serviced at the next sync.
- Total sequence with i_rdy=1: sync cycle + 6 cycles.

Test Plan:
- Release reset, i_sync=1 → o_force_brk=1, then states 1..6. o_write=0 throughout, o_sp_dec=1 for 3 cycles, o_vec_addr=FFFC then FFFD, o_set_i=1 one cycle, rst_pend cleared.
- i_brk=1 at sync, no pending sources → o_force_brk=0, o_pc_inc=1 in DUMMY, writes PCH/PCL/P with o_b_flag=1 in PUSH_P, vector FFFE/FFFF.
- i_irq_n=0 with i_p_i=1 at sync → no sequence. With i_p_i=0 → forced sequence, o_b_flag=0, vector FFFE.
- IRQ sequence with i_nmi_n falling during PUSH_PCL → vector FFFA/FFFB, o_nmi_taken pulse, nmi_pend cleared. NMI falling during VEC_HI → serviced at next sync.
- i_rdy=0 for 3 cycles in DUMMY and again in VEC_LO → state holds. o_set_i stays high while held. Push states are never stalled.
- Reset asserted in PUSH_PCL → next cycle IDLE, outputs 0. The next sync runs the reset sequence (vector FFFC).
